iobus_uart_tx: RTL and testbench

IOBUS_UART_TX -- requirements
Module: iobus_uart_tx

---
 rtl/iobus_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_iobus_uart_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/iobus_uart_tx.sv
// iobus_uart_tx -- memory-mapped UART transmitter with a byte FIFO.
//
// The CPU stores bytes to DATA (BASE_ADDR). They are queued in a FIFO and sent
// as 8N1 frames (start, 8 data bits LSB first, stop). Frames follow each other
// with no idle gap while the FIFO holds data. STATUS (BASE_ADDR+4) reports
// full/empty/in-flight/overflow and the FIFO count. Writing STATUS with bit 3
// set clears the sticky overflow flag.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous reset, active low
//   IOBUS_ADDR in   [31:0] bus address
//   IOBUS_OUT  in   [31:0] bus write data (DATA uses bits [7:0] only)
//   IOBUS_WR   in   bus write strobe, one cycle per store
//   IOBUS_IN   out  [31:0] combinational read data (STATUS, else 0)
//   TX         out  serial line, idle high (registered)
//   BUSY       out  frame in flight or FIFO non-empty (registered)
module iobus_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0040
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX,
  output logic        BUSY
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam int          BW        = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      fifo_mem_q [FIFO_DEPTH];

  logic full, empty, wr_data, wr_stat, push, pop, baud_done;
  logic unused_bits;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign wr_data   = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR);
  assign wr_stat   = IOBUS_WR && (IOBUS_ADDR == STAT_ADDR);
  assign baud_done = (baud_q == BAUD_LAST);
  // Fullness comes from the registered count, so a pop on the same edge
  // never makes room for a push.
  assign push      = wr_data && !full;
  // Pops are decided from the registered count: a byte pushed this edge
  // cannot be the one popped.
  assign pop       = !empty && ((state_q == IDLE) || ((state_q == STOP) && baud_done));
  assign unused_bits = ^{IOBUS_OUT[31:8]};

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    // TX is registered, so it is computed for the state being entered.
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (pop) begin
          state_d = START;
          shift_d = fifo_mem_q[rd_ptr_q];
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (pop) begin
            state_d = START;
            shift_d = fifo_mem_q[rd_ptr_q];
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    // A set and a clear in the same cycle: the set wins.
    ovf_d = ovf_q;
    if (wr_stat && IOBUS_OUT[3]) ovf_d = 1'b0;
    if (wr_data && full)         ovf_d = 1'b1;

    busy_d = (count_d != '0) || (state_d != IDLE);
  end

  // Control state: reset applies here
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Datapath: shift register, bit index and FIFO storage carry no reset
  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
    bit_q   <= bit_d;
    if (RST && push) fifo_mem_q[wr_ptr_q] <= IOBUS_OUT[7:0];
  end

  always_comb begin
    IOBUS_IN = '0;
    if (IOBUS_ADDR == STAT_ADDR) begin
      IOBUS_IN[0]    = full;
      IOBUS_IN[1]    = empty;
      IOBUS_IN[2]    = (state_q != IDLE);
      IOBUS_IN[3]    = ovf_q;
      IOBUS_IN[15:8] = 8'(count_q);
    end
  end

  assign TX   = tx_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// tb_iobus_uart_tx -- self-checking bench for iobus_uart_tx (CLKS_PER_BIT=4,
// FIFO_DEPTH=4). A frame-level reference model (byte queue plus a time index
// into the current 10-bit frame) predicts TX, BUSY and STATUS every cycle.
module tb_iobus_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'h1100_0040;
  localparam logic [31:0] STAT  = 32'h1100_0044;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  always #5 clk = ~clk;

  iobus_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .IOBUS_ADDR(addr),
    .IOBUS_OUT (wdata),
    .IOBUS_WR  (wr),
    .IOBUS_IN  (rdata),
    .TX        (tx),
    .BUSY      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] m_cur = '0;
  bit         m_inflight = 1'b0;
  int         m_t = 0;
  bit         m_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d);
    bit do_pop, push_ok, ovf_set, ovf_clr;
    if (!r) begin
      mq.delete();
      m_inflight = 1'b0;
      m_t = 0;
      m_ovf = 1'b0;
      return;
    end
    do_pop  = (mq.size() != 0) && (!m_inflight || m_t == FRAME - 1);
    push_ok = w && (a == BASE) && (mq.size() < DEPTH);
    ovf_set = w && (a == BASE) && (mq.size() == DEPTH);
    ovf_clr = w && (a == STAT) && d[3];
    if (do_pop) begin
      m_cur = mq.pop_front();
      m_t = 0;
      m_inflight = 1'b1;
    end else if (m_inflight) begin
      if (m_t == FRAME - 1) m_inflight = 1'b0;
      else m_t++;
    end
    if (push_ok) mq.push_back(d[7:0]);
    if (ovf_set) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  function automatic logic exp_tx();
    int b;
    if (!m_inflight) return 1'b1;
    b = m_t / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (mq.size() == DEPTH);
    s[1] = (mq.size() == 0);
    s[2] = m_inflight;
    s[3] = m_ovf;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  // One clock: drive inputs, take the edge, compare outputs and STATUS.
  task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rst_n = r;
    wr    = w;
    addr  = a;
    wdata = d;
    if (a != STAT) begin
      #1;
      check("rd_nonstatus", 64'(rdata), 64'h0);
    end
    @(posedge clk);
    model_edge(r, w, a, d);
    #1;
    check("tx", 64'(tx), 64'(exp_tx()));
    check("busy", 64'(busy), 64'(m_inflight || mq.size() != 0));
    wr   = 1'b0;
    addr = STAT;
    #1;
    check("status", 64'(rdata), 64'(exp_status()));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b1, 1'b0, STAT, 32'h0);
  endtask

  initial begin
    int n, run, max_run;
    logic [39:0] seq, exp_seq;
    logic pat [10];
    logic r, w;
    logic [31:0] a, d;
    int sel;

    // Reset state and address decode
    repeat (3) cycle(1'b0, 1'b1, BASE, 32'h55);
    check("reset_tx", 64'(tx), 64'h1);
    check("reset_busy", 64'(busy), 64'h0);
    addr = STAT; #1;
    check("stat_idle", 64'(rdata), 64'h2);
    addr = BASE; #1;
    check("rd_base", 64'(rdata), 64'h0);
    addr = 32'h1100_0000; #1;
    check("rd_other", 64'(rdata), 64'h0);
    idle(2);

    // Single byte A5, upper write bits ignored
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 40; k++) exp_seq[k] = pat[k / 4];
    seq = '0;
    cycle(1'b1, 1'b1, BASE, 32'hFFFF_FFA5);
    n = 0;
    while (busy && n < 100) begin
      idle(1);
      n++;
      if (n >= 1 && n <= 40) seq[n-1] = tx;
    end
    check("a5_busy_fall_cycle", 64'(n), 64'd41);
    check("a5_waveform", 64'(seq), 64'(exp_seq));
    idle(3);

    // Back-to-back frames
    cycle(1'b1, 1'b1, BASE, 32'h01);
    cycle(1'b1, 1'b1, BASE, 32'h02);
    run = 0;
    max_run = 0;
    for (int k = 0; k < 100; k++) begin
      idle(1);
      if (busy && tx) run++;
      else run = 0;
      if (run > max_run) max_run = run;
    end
    check("b2b_max_high_run", 64'(max_run), 64'd4);
    check("b2b_done_busy", 64'(busy), 64'h0);

    // Overflow
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, BASE, 32'h10 + 32'(k));
    check("ovf_status", 64'(rdata), 64'h40D);
    cycle(1'b1, 1'b1, STAT, 32'h8);
    check("ovf_clear", 64'(rdata), 64'h405);
    idle(220);
    check("ovf_drained", 64'(rdata), 64'h2);

    // Reset during data bit 3 with two bytes queued
    cycle(1'b1, 1'b1, BASE, 32'hC6);
    cycle(1'b1, 1'b1, BASE, 32'h33);
    cycle(1'b1, 1'b1, BASE, 32'h44);
    idle(15);
    cycle(1'b0, 1'b1, BASE, 32'h99);
    check("midrst_tx", 64'(tx), 64'h1);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_status", 64'(rdata), 64'h2);
    idle(100);
    check("midrst_quiet", 64'(rdata), 64'h2);

    // Push on the same edge as the STOP->START pop
    cycle(1'b1, 1'b1, BASE, 32'h3C);
    cycle(1'b1, 1'b1, BASE, 32'hC3);
    idle(39);
    cycle(1'b1, 1'b1, BASE, 32'h5A);
    check("samedge_count", 64'(rdata), 64'h104);
    idle(100);
    check("samedge_done", 64'(rdata), 64'h2);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 149) != 0);
      sel = $urandom_range(0, 9);
      d = $urandom;
      a = $urandom;
      w = 1'b0;
      if (sel <= 2) begin w = 1'b1; a = BASE; end
      else if (sel == 3) begin w = 1'b1; a = STAT; end
      else if (sel == 4) w = 1'b1;
      cycle(r, w, a, d);
    end
    cycle(1'b1, 1'b1, STAT, 32'h8);
    idle(260);
    check("random_drained", 64'(rdata), 64'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
